axis_wr_frame_sched: RTL and testbench

Single-clock frame write scheduler for the AXI video bridge. It sits between the write-side clock-crossing FIFO (read port, AXI clock domain) and the AXI DMA write descriptor, data and status interfaces. It splits each frame into fixed-size bursts and issues one descriptor per burst with a correct `tlast`. It rotates frames across a ring of N frame buffers and skips the buffer the display reader currently holds.

---
 rtl/axis_wr_frame_sched.sv | 172 +++++++++++++++++
 tb/tb_axis_wr_frame_sched.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_wr_frame_sched.sv
// Frame write scheduler: cuts each frame from the CDC FIFO into fixed-size DMA bursts,
// one descriptor per burst, and rotates frames over a buffer ring avoiding the reader's buffer.
module axis_wr_frame_sched #(
  parameter int AXI_DATA_WIDTH = 256,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int TAG_WIDTH      = 8,
  parameter int BURST_LEN      = 64,
  parameter int NUM_BUFFERS    = 3,
  parameter logic [AXI_ADDR_WIDTH-1:0] BUF_BASE_ADDR = 32'h1000_0000,
  parameter logic [AXI_ADDR_WIDTH-1:0] BUF_STRIDE    = 32'h0200_0000,
  parameter int LEVEL_WIDTH    = 16,
  localparam int BYTES         = AXI_DATA_WIDTH / 8,
  localparam int BUF_IDX_W     = (NUM_BUFFERS > 1) ? $clog2(NUM_BUFFERS) : 1
) (
  input  logic                      axi_clk,
  input  logic                      axi_rst,
  input  logic                      i_frame_start,
  input  logic [23:0]               i_frame_beats,
  input  logic                      i_rd_buf_lock,
  input  logic [BUF_IDX_W-1:0]      i_rd_buf_idx,
  input  logic [AXI_DATA_WIDTH-1:0] s_fifo_tdata,
  input  logic                      s_fifo_tvalid,
  output logic                      s_fifo_tready,
  input  logic [LEVEL_WIDTH-1:0]    i_fifo_level,
  output logic [AXI_ADDR_WIDTH-1:0] m_desc_addr,
  output logic [31:0]               m_desc_len,
  output logic [TAG_WIDTH-1:0]      m_desc_tag,
  output logic                      m_desc_valid,
  input  logic                      m_desc_ready,
  input  logic [TAG_WIDTH-1:0]      s_status_tag,
  input  logic                      s_status_valid,
  output logic [AXI_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [BYTES-1:0]          m_axis_tkeep,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast,
  output logic                      o_frame_done,
  output logic [BUF_IDX_W-1:0]      o_done_buf_idx,
  output logic                      o_busy,
  output logic [15:0]               o_drop_cnt
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [BUF_IDX_W-1:0] LAST_IDX = BUF_IDX_W'(NUM_BUFFERS - 1);

  typedef enum logic [2:0] {
    IDLE, SEL_BUF, WAIT_DATA, SEND_DESC, STREAM, WAIT_STATUS
  } state_t;

  state_t state, state_nxt;

  logic [23:0]               nbursts_q, burst_idx_q, nbursts_c, beats_rem;
  logic [CNT_W-1:0]          last_beats_q, beat_cnt_q, cur_beats, last_beats_c;
  logic [BUF_IDX_W-1:0]      cur_buf_q, last_buf_q, done_buf_q;
  logic [BUF_IDX_W-1:0]      cand_buf, skip_buf, sel_buf;
  logic [AXI_ADDR_WIDTH-1:0] desc_addr_q, addr_c;
  logic [31:0]               desc_len_q;
  logic [TAG_WIDTH-1:0]      desc_tag_q;
  logic [15:0]               drop_cnt_q;
  logic                      frame_done_q;
  logic                      frame_go, is_final, level_ok, beat_fire, last_beat, status_hit;

  // Burst split: a remainder of zero means the final burst is a full one.
  assign frame_go     = i_frame_start && (i_frame_beats != '0);
  assign nbursts_c    = 24'((32'(i_frame_beats) + 32'(BURST_LEN - 1)) / 32'(BURST_LEN));
  assign beats_rem    = 24'(32'(i_frame_beats) % 32'(BURST_LEN));
  assign last_beats_c = (beats_rem == '0) ? CNT_W'(BURST_LEN) : CNT_W'(beats_rem);

  assign cand_buf = (last_buf_q == LAST_IDX) ? '0 : last_buf_q + 1'b1;
  assign skip_buf = (cand_buf == LAST_IDX) ? '0 : cand_buf + 1'b1;
  assign sel_buf  = (i_rd_buf_lock && (i_rd_buf_idx == cand_buf)) ? skip_buf : cand_buf;

  assign is_final   = (burst_idx_q == nbursts_q - 24'd1);
  assign cur_beats  = is_final ? last_beats_q : CNT_W'(BURST_LEN);
  assign level_ok   = (32'(i_fifo_level) >= 32'(cur_beats));
  assign beat_fire  = s_fifo_tvalid && m_axis_tready;
  assign last_beat  = (beat_cnt_q == cur_beats - CNT_W'(1));
  assign status_hit = s_status_valid && (s_status_tag == desc_tag_q);

  // Modular arithmetic in the address width gives the required truncation for free.
  assign addr_c = BUF_BASE_ADDR + AXI_ADDR_WIDTH'(cur_buf_q) * BUF_STRIDE
                + AXI_ADDR_WIDTH'(burst_idx_q) * AXI_ADDR_WIDTH'(BURST_LEN * BYTES);

  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt     = state;
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    s_fifo_tready = 1'b0;
    m_axis_tlast  = 1'b0;
    case (state)
      IDLE:        if (frame_go) state_nxt = SEL_BUF;
      SEL_BUF:     state_nxt = WAIT_DATA;
      WAIT_DATA:   if (level_ok) state_nxt = SEND_DESC;
      SEND_DESC:   if (m_desc_ready) state_nxt = STREAM;
      STREAM: begin
        m_axis_tdata  = s_fifo_tdata;
        m_axis_tvalid = s_fifo_tvalid;
        s_fifo_tready = m_axis_tready;
        m_axis_tlast  = last_beat;
        if (beat_fire && last_beat) state_nxt = WAIT_STATUS;
      end
      WAIT_STATUS: if (status_hit) state_nxt = is_final ? IDLE : WAIT_DATA;
      default:     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      nbursts_q    <= '0;
      last_beats_q <= '0;
      burst_idx_q  <= '0;
      beat_cnt_q   <= '0;
      cur_buf_q    <= '0;
      last_buf_q   <= LAST_IDX;
      desc_addr_q  <= '0;
      desc_len_q   <= '0;
      desc_tag_q   <= '0;
      frame_done_q <= 1'b0;
      done_buf_q   <= '0;
      drop_cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register here reading pre-edge values.
      frame_done_q <= 1'b0;
      case (state)
        IDLE: if (frame_go) begin
          nbursts_q    <= nbursts_c;
          last_beats_q <= last_beats_c;
        end
        SEL_BUF: begin
          cur_buf_q   <= sel_buf;
          burst_idx_q <= '0;
        end
        WAIT_DATA: if (level_ok) begin
          desc_addr_q <= addr_c;
          desc_len_q  <= 32'(cur_beats) * 32'(BYTES);
          desc_tag_q  <= TAG_WIDTH'(burst_idx_q);
          beat_cnt_q  <= '0;
        end
        STREAM: if (beat_fire) beat_cnt_q <= last_beat ? '0 : beat_cnt_q + CNT_W'(1);
        WAIT_STATUS: if (status_hit) begin
          if (is_final) begin
            last_buf_q   <= cur_buf_q;
            done_buf_q   <= cur_buf_q;
            frame_done_q <= 1'b1;
          end else begin
            burst_idx_q <= burst_idx_q + 24'd1;
          end
        end
        default: ;
      endcase
      if (i_frame_start && (state != IDLE) && (drop_cnt_q != 16'hFFFF))
        drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign m_desc_addr    = desc_addr_q;
  assign m_desc_len     = desc_len_q;
  assign m_desc_tag     = desc_tag_q;
  assign m_desc_valid   = (state == SEND_DESC);
  assign m_axis_tkeep   = '1;
  assign o_frame_done   = frame_done_q;
  assign o_done_buf_idx = done_buf_q;
  assign o_busy         = (state != IDLE) || frame_done_q;
  assign o_drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_axis_wr_frame_sched.sv
// Directed bench for axis_wr_frame_sched: a cycle-driven frame runner with a show-ahead
// FIFO model and status responder, and one task per scenario with inline comparisons.
`timescale 1ns/1ps
module tb_axis_wr_frame_sched;

  logic         axi_clk = 1'b0;
  logic         axi_rst = 1'b1;
  logic         i_frame_start = 1'b0;
  logic [23:0]  i_frame_beats = '0;
  logic         i_rd_buf_lock = 1'b0;
  logic [1:0]   i_rd_buf_idx = '0;
  logic [255:0] s_fifo_tdata;
  logic         s_fifo_tvalid = 1'b1;
  logic         s_fifo_tready;
  logic [15:0]  i_fifo_level = 16'd1000;
  logic [31:0]  m_desc_addr;
  logic [31:0]  m_desc_len;
  logic [7:0]   m_desc_tag;
  logic         m_desc_valid;
  logic         m_desc_ready = 1'b0;
  logic [7:0]   s_status_tag = '0;
  logic         s_status_valid = 1'b0;
  logic [255:0] m_axis_tdata;
  logic [31:0]  m_axis_tkeep;
  logic         m_axis_tvalid;
  logic         m_axis_tready = 1'b1;
  logic         m_axis_tlast;
  logic         o_frame_done;
  logic [1:0]   o_done_buf_idx;
  logic         o_busy;
  logic [15:0]  o_drop_cnt;

  logic [31:0] fifo_head = 32'h100;
  assign s_fifo_tdata = {8{fifo_head}};

  always #5 axi_clk = ~axi_clk;

  axis_wr_frame_sched dut (
    .axi_clk(axi_clk), .axi_rst(axi_rst),
    .i_frame_start(i_frame_start), .i_frame_beats(i_frame_beats),
    .i_rd_buf_lock(i_rd_buf_lock), .i_rd_buf_idx(i_rd_buf_idx),
    .s_fifo_tdata(s_fifo_tdata), .s_fifo_tvalid(s_fifo_tvalid), .s_fifo_tready(s_fifo_tready),
    .i_fifo_level(i_fifo_level),
    .m_desc_addr(m_desc_addr), .m_desc_len(m_desc_len), .m_desc_tag(m_desc_tag),
    .m_desc_valid(m_desc_valid), .m_desc_ready(m_desc_ready),
    .s_status_tag(s_status_tag), .s_status_valid(s_status_valid),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .o_frame_done(o_frame_done), .o_done_buf_idx(o_done_buf_idx),
    .o_busy(o_busy), .o_drop_cnt(o_drop_cnt)
  );

  int cmp_cnt = 0;
  int mis_cnt = 0;

  // Observations from the last run_frame call.
  logic [31:0] d_addr[$];
  logic [31:0] d_len[$];
  logic [7:0]  d_tag[$];
  int nbeats, data_err, last_err, tlast_cnt, outside_err, gate_viol, stab_err;
  int first_desc_c, done_c, last_stat_c;
  bit timeout, busy_c1, done_seen, done_busy, done_after;
  logic [1:0] done_idx;

  task automatic do_reset();
    @(posedge axi_clk); #1;
    axi_rst = 1'b1;
    i_frame_start = 1'b0; s_status_valid = 1'b0; m_desc_ready = 1'b0;
    repeat (2) @(posedge axi_clk);
    #1 axi_rst = 1'b0;
  endtask

  // Drives one frame cycle by cycle: inputs at posedge+1, observations at posedge+2.
  task automatic run_frame(input int beats, input bit rand_bp, input int desc_delay,
                           input bit stray, input bit gate, input bit drops,
                           input bit lock, input int lock_idx, input int abort_at);
    int c, exp_bursts, bursts_done, desc_wait, stray_due, beat_in_burst;
    int stat_due[$];
    logic [7:0] stat_tag[$];
    logic [39:0] held;
    logic [31:0] exp_word;
    bit in_burst, drop1, drop2, aborted, exp_last;
    d_addr.delete(); d_len.delete(); d_tag.delete();
    nbeats = 0; data_err = 0; last_err = 0; tlast_cnt = 0; outside_err = 0;
    gate_viol = 0; stab_err = 0; first_desc_c = -1; done_c = -100; last_stat_c = -1000;
    timeout = 0; busy_c1 = 0; done_seen = 0; done_busy = 0; done_after = 0; done_idx = 'x;
    exp_bursts = (beats + 63) / 64;
    bursts_done = 0; desc_wait = 0; stray_due = -1; beat_in_burst = 0;
    in_burst = 0; drop1 = 0; drop2 = 0; aborted = 0; held = '0;
    exp_word = fifo_head;
    c = 0;
    while (!done_seen && c < 4000) begin
      @(posedge axi_clk); #1;
      if (abort_at > 0 && nbeats == abort_at) begin
        axi_rst = 1'b1;
        aborted = 1;
        break;
      end
      i_frame_beats = 24'(beats);
      i_frame_start = (c == 0);
      if (drops && in_burst && nbeats == 10 && !drop1) begin i_frame_start = 1'b1; drop1 = 1; end
      if (drops && in_burst && nbeats == 20 && !drop2) begin i_frame_start = 1'b1; drop2 = 1; end
      i_rd_buf_lock = lock;
      i_rd_buf_idx  = 2'(lock_idx);
      if (gate) i_fifo_level = (c < 30) ? 16'd0 : (c < 40) ? 16'd63 : 16'd64;
      else      i_fifo_level = 16'd1000;
      m_desc_ready = 1'b0;
      if (m_desc_valid) begin
        m_desc_ready = (desc_wait >= desc_delay);
        desc_wait++;
      end else begin
        desc_wait = 0;
      end
      m_axis_tready = rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_fifo_tvalid = rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_status_valid = 1'b0;
      s_status_tag   = '0;
      if (stat_due.size() > 0 && stat_due[0] == c) begin
        s_status_valid = 1'b1;
        s_status_tag   = stat_tag[0];
        if (int'(stat_tag[0]) == exp_bursts - 1) last_stat_c = c;
        void'(stat_due.pop_front());
        void'(stat_tag.pop_front());
      end else if (stray && c == stray_due) begin
        s_status_valid = 1'b1;
        s_status_tag   = 8'd7;
      end
      #1;
      if (c == 1) busy_c1 = o_busy;
      if (m_desc_valid && first_desc_c < 0) first_desc_c = c;
      if (gate && c <= 40 && m_desc_valid) gate_viol++;
      if (m_desc_valid) begin
        if (desc_wait > 1 && {m_desc_addr, m_desc_tag} !== held) stab_err++;
        held = {m_desc_addr, m_desc_tag};
      end
      if (!in_burst && (m_axis_tvalid || s_fifo_tready || m_axis_tlast)) outside_err++;
      if (m_desc_valid && m_desc_ready) begin
        d_addr.push_back(m_desc_addr);
        d_len.push_back(m_desc_len);
        d_tag.push_back(m_desc_tag);
        in_burst = 1;
        beat_in_burst = 0;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (m_axis_tdata !== {8{exp_word}}) data_err++;
        exp_last = ((nbeats + 1) % 64 == 0) || (nbeats + 1 == beats);
        if (m_axis_tlast !== exp_last) last_err++;
        if (m_axis_tlast) begin
          tlast_cnt++;
          stat_due.push_back(c + (stray ? 6 : 3));
          stat_tag.push_back(8'(bursts_done));
          if (stray) stray_due = c + 2;
          bursts_done++;
          in_burst = 0;
        end
        nbeats++;
        beat_in_burst++;
        exp_word++;
      end
      if (s_fifo_tvalid && s_fifo_tready) fifo_head++;
      if (o_frame_done) begin
        done_seen = 1;
        done_c    = c;
        done_idx  = o_done_buf_idx;
        done_busy = o_busy;
      end
      c++;
    end
    if (!aborted) begin
      if (!done_seen) timeout = 1;
      @(posedge axi_clk); #1;
      i_frame_start = 1'b0; s_status_valid = 1'b0; m_desc_ready = 1'b0;
      m_axis_tready = 1'b1; s_fifo_tvalid = 1'b1; i_rd_buf_lock = 1'b0;
      #1 done_after = o_frame_done;
    end
  endtask

  task automatic test_reset();
    #3;
    cmp_cnt++; if ({m_desc_valid, m_axis_tvalid, s_fifo_tready, m_axis_tlast, o_busy, o_frame_done} !== 6'b0) begin mis_cnt++; $display("FAIL reset.ctrl got %b want 000000", {m_desc_valid, m_axis_tvalid, s_fifo_tready, m_axis_tlast, o_busy, o_frame_done}); end
    cmp_cnt++; if ({m_desc_addr, m_desc_len, m_desc_tag} !== 72'h0) begin mis_cnt++; $display("FAIL reset.desc got %h want 0", {m_desc_addr, m_desc_len, m_desc_tag}); end
    cmp_cnt++; if ({o_drop_cnt, o_done_buf_idx} !== 18'h0) begin mis_cnt++; $display("FAIL reset.cnt got %h want 0", {o_drop_cnt, o_done_buf_idx}); end
    cmp_cnt++; if (m_axis_tdata !== 256'h0) begin mis_cnt++; $display("FAIL reset.tdata got %h want 0", m_axis_tdata[31:0]); end
    do_reset();
    repeat (3) @(posedge axi_clk);
    #2;
    cmp_cnt++; if (o_busy !== 1'b0) begin mis_cnt++; $display("FAIL reset.idle_busy got %b want 0", o_busy); end
  endtask

  task automatic test_full_burst();
    run_frame(128, 0, 0, 0, 0, 0, 0, 0, 0);
    cmp_cnt++; if (timeout !== 1'b0) begin mis_cnt++; $display("FAIL full.timeout got %b want 0", timeout); end
    cmp_cnt++; if (busy_c1 !== 1'b1) begin mis_cnt++; $display("FAIL full.busy_c1 got %b want 1", busy_c1); end
    cmp_cnt++; if (first_desc_c !== 3) begin mis_cnt++; $display("FAIL full.desc_cycle got %0d want 3", first_desc_c); end
    cmp_cnt++; if (d_addr.size() !== 2) begin mis_cnt++; $display("FAIL full.ndesc got %0d want 2", d_addr.size()); end
    cmp_cnt++; if ({d_addr[0], d_len[0], d_tag[0]} !== {32'h1000_0000, 32'd2048, 8'd0}) begin mis_cnt++; $display("FAIL full.desc0 got %h/%0d/%0d want 10000000/2048/0", d_addr[0], d_len[0], d_tag[0]); end
    cmp_cnt++; if ({d_addr[1], d_len[1], d_tag[1]} !== {32'h1000_0800, 32'd2048, 8'd1}) begin mis_cnt++; $display("FAIL full.desc1 got %h/%0d/%0d want 10000800/2048/1", d_addr[1], d_len[1], d_tag[1]); end
    cmp_cnt++; if (nbeats !== 128) begin mis_cnt++; $display("FAIL full.beats got %0d want 128", nbeats); end
    cmp_cnt++; if ({tlast_cnt, last_err} !== {32'd2, 32'd0}) begin mis_cnt++; $display("FAIL full.tlast got %0d lasts %0d errs want 2/0", tlast_cnt, last_err); end
    cmp_cnt++; if ({data_err, outside_err} !== 64'd0) begin mis_cnt++; $display("FAIL full.data got %0d/%0d want 0/0", data_err, outside_err); end
    cmp_cnt++; if (done_idx !== 2'd0) begin mis_cnt++; $display("FAIL full.done_idx got %0d want 0", done_idx); end
    cmp_cnt++; if (done_c - last_stat_c !== 1) begin mis_cnt++; $display("FAIL full.done_gap got %0d want 1", done_c - last_stat_c); end
    cmp_cnt++; if ({done_busy, done_after} !== 2'b10) begin mis_cnt++; $display("FAIL full.done_pulse got %b want 10", {done_busy, done_after}); end
    cmp_cnt++; if (m_axis_tkeep !== 32'hFFFF_FFFF) begin mis_cnt++; $display("FAIL full.tkeep got %h want ffffffff", m_axis_tkeep); end
  endtask

  task automatic test_remainder();
    run_frame(100, 0, 0, 0, 0, 0, 0, 0, 0);
    cmp_cnt++; if (d_addr.size() !== 2) begin mis_cnt++; $display("FAIL rem.ndesc got %0d want 2", d_addr.size()); end
    cmp_cnt++; if ({d_addr[0], d_len[0]} !== {32'h1200_0000, 32'd2048}) begin mis_cnt++; $display("FAIL rem.desc0 got %h/%0d want 12000000/2048", d_addr[0], d_len[0]); end
    cmp_cnt++; if ({d_addr[1], d_len[1], d_tag[1]} !== {32'h1200_0800, 32'd1152, 8'd1}) begin mis_cnt++; $display("FAIL rem.desc1 got %h/%0d/%0d want 12000800/1152/1", d_addr[1], d_len[1], d_tag[1]); end
    cmp_cnt++; if ({nbeats, tlast_cnt, last_err} !== {32'd100, 32'd2, 32'd0}) begin mis_cnt++; $display("FAIL rem.beats got %0d/%0d/%0d want 100/2/0", nbeats, tlast_cnt, last_err); end
    cmp_cnt++; if (done_idx !== 2'd1) begin mis_cnt++; $display("FAIL rem.done_idx got %0d want 1", done_idx); end
  endtask

  task automatic test_backpressure();
    run_frame(128, 1, 5, 1, 1, 0, 0, 0, 0);
    cmp_cnt++; if (timeout !== 1'b0) begin mis_cnt++; $display("FAIL bp.timeout got %b want 0", timeout); end
    cmp_cnt++; if ({nbeats, data_err, last_err} !== {32'd128, 32'd0, 32'd0}) begin mis_cnt++; $display("FAIL bp.beats got %0d/%0d/%0d want 128/0/0", nbeats, data_err, last_err); end
    cmp_cnt++; if ({gate_viol, first_desc_c} !== {32'd0, 32'd41}) begin mis_cnt++; $display("FAIL bp.gate got %0d/%0d want 0/41", gate_viol, first_desc_c); end
    cmp_cnt++; if ({stab_err, outside_err} !== 64'd0) begin mis_cnt++; $display("FAIL bp.stable got %0d/%0d want 0/0", stab_err, outside_err); end
    cmp_cnt++; if ({d_addr[0], d_addr[1], d_tag[1]} !== {32'h1400_0000, 32'h1400_0800, 8'd1}) begin mis_cnt++; $display("FAIL bp.desc got %h/%h/%0d want 14000000/14000800/1", d_addr[0], d_addr[1], d_tag[1]); end
    cmp_cnt++; if ({done_idx, 32'(done_c - last_stat_c)} !== {2'd2, 32'd1}) begin mis_cnt++; $display("FAIL bp.done got %0d/%0d want 2/1", done_idx, done_c - last_stat_c); end
  endtask

  task automatic test_drops();
    @(posedge axi_clk); #1;
    i_frame_beats = 24'd0; i_frame_start = 1'b1;
    @(posedge axi_clk); #1;
    i_frame_start = 1'b0;
    repeat (2) @(posedge axi_clk);
    #2;
    cmp_cnt++; if ({o_busy, o_drop_cnt} !== 17'd0) begin mis_cnt++; $display("FAIL drop.zero_beats got %b/%0d want 0/0", o_busy, o_drop_cnt); end
    run_frame(128, 0, 0, 0, 0, 1, 0, 0, 0);
    cmp_cnt++; if (o_drop_cnt !== 16'd2) begin mis_cnt++; $display("FAIL drop.count got %0d want 2", o_drop_cnt); end
    cmp_cnt++; if ({nbeats, data_err, d_addr.size()} !== {32'd128, 32'd0, 32'd2}) begin mis_cnt++; $display("FAIL drop.frame got %0d/%0d/%0d want 128/0/2", nbeats, data_err, d_addr.size()); end
    cmp_cnt++; if ({timeout, done_idx} !== {1'b0, 2'd0}) begin mis_cnt++; $display("FAIL drop.done got %b/%0d want 0/0", timeout, done_idx); end
  endtask

  task automatic test_ring();
    int exp_free[4];
    int exp_lock[4];
    exp_free = '{0, 1, 2, 0};
    exp_lock = '{0, 2, 0, 1};
    do_reset();
    for (int f = 0; f < 4; f++) begin
      run_frame(10, 0, 0, 0, 0, 0, 0, 0, 0);
      cmp_cnt++; if (done_idx !== 2'(exp_free[f])) begin mis_cnt++; $display("FAIL ring.free%0d got %0d want %0d", f, done_idx, exp_free[f]); end
    end
    do_reset();
    for (int f = 0; f < 4; f++) begin
      run_frame(10, 0, 0, 0, 0, 0, (f == 1), 1, 0);
      cmp_cnt++; if (done_idx !== 2'(exp_lock[f])) begin mis_cnt++; $display("FAIL ring.lock%0d got %0d want %0d", f, done_idx, exp_lock[f]); end
    end
  endtask

  task automatic test_reset_mid_stream();
    run_frame(128, 0, 0, 0, 0, 0, 0, 0, 30);
    #1;
    cmp_cnt++; if ({m_desc_valid, m_axis_tvalid, s_fifo_tready, m_axis_tlast, o_busy, o_frame_done} !== 6'b0) begin mis_cnt++; $display("FAIL midrst.ctrl got %b want 000000", {m_desc_valid, m_axis_tvalid, s_fifo_tready, m_axis_tlast, o_busy, o_frame_done}); end
    cmp_cnt++; if ({m_desc_addr, m_desc_len, m_desc_tag, o_done_buf_idx, o_drop_cnt} !== 90'h0) begin mis_cnt++; $display("FAIL midrst.regs got %h/%0d/%0d want 0", m_desc_addr, m_desc_len, m_desc_tag); end
    cmp_cnt++; if (m_axis_tdata !== 256'h0) begin mis_cnt++; $display("FAIL midrst.tdata got %h want 0", m_axis_tdata[31:0]); end
    do_reset();
    run_frame(64, 0, 0, 0, 0, 0, 0, 0, 0);
    cmp_cnt++; if (d_addr.size() !== 1) begin mis_cnt++; $display("FAIL midrst.ndesc got %0d want 1", d_addr.size()); end
    cmp_cnt++; if ({d_addr[0], d_tag[0]} !== {32'h1000_0000, 8'd0}) begin mis_cnt++; $display("FAIL midrst.desc got %h/%0d want 10000000/0", d_addr[0], d_tag[0]); end
    cmp_cnt++; if ({timeout, done_idx, nbeats} !== {1'b0, 2'd0, 32'd64}) begin mis_cnt++; $display("FAIL midrst.done got %b/%0d/%0d want 0/0/64", timeout, done_idx, nbeats); end
  endtask

  initial begin
    test_reset();
    test_full_burst();
    test_remainder();
    test_backpressure();
    test_drops();
    test_ring();
    test_reset_mid_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

endmodule
